pcm_sample_buffer: RTL and testbench

Producer end of the ready/valid sample-read interface used by the VU meter and other audio consumers. Captures one channel of the 24-bit I2S capture stream (strobe = i2s_capture_24.ready_o) into an inferred single-port-read RAM ring buffer. Presents buffered samples on a registered ready/valid read port (read_data_o, read_valid_o, read_ready_i) plus a fill-threshold flag, buffer_ready_o. Sits between i2s_capture_24 and the consumer, all in the 27 MHz clk_i domain.

---
 rtl/pcm_sample_buffer.sv | 127 ++++++++++++
 tb/tb_pcm_sample_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_sample_buffer.sv
// Ring buffer for one I2S capture channel, drained through a registered
// ready/valid read port with a fill-threshold flag and a sticky overflow flag.
module pcm_sample_buffer #(
  parameter logic SELECT_LEFT = 1'b1,
  parameter int   DEPTH       = 256,
  parameter int   READY_LEVEL = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sample_valid_i,
  input  logic [23:0]                 left_sample_i,
  input  logic [23:0]                 right_sample_i,
  input  logic                        clear_i,
  output logic [23:0]                 read_data_o,
  output logic                        read_valid_o,
  input  logic                        read_ready_i,
  output logic                        buffer_ready_o,
  output logic [$clog2(DEPTH+2)-1:0]  fill_level_o,
  output logic                        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+2);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StValid
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wrPtr_q, wrPtr_d;
  logic [AW-1:0]   rdPtr_q, rdPtr_d;
  logic [FW-1:0]   memCount_q, memCount_d;
  logic [23:0]     readData_q, readData_d;
  logic            overflow_q, overflow_d;
  logic [23:0]     ramData_q;
  logic [23:0]     mem [DEPTH];

  logic            flush;
  logic            doWrite;
  logic            doFetch;
  logic            memNonEmpty;
  logic [23:0]     selSample;

  assign flush       = rst_i | clear_i;
  assign selSample   = SELECT_LEFT ? left_sample_i : right_sample_i;
  assign doWrite     = sample_valid_i && (memCount_q < FW'(DEPTH));
  assign memNonEmpty = (memCount_q != '0);

  always_comb begin
    state_d    = state_q;
    doFetch    = 1'b0;
    readData_d = readData_q;
    case (state_q)
      StIdle: begin
        if (memNonEmpty) begin
          doFetch = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        readData_d = ramData_q;
        state_d    = StValid;
      end
      StValid: begin
        // An accept can immediately launch the next fetch, giving one sample per two cycles.
        if (read_ready_i) begin
          if (memNonEmpty) begin
            doFetch = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wrPtr_d    = doWrite ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d    = doFetch ? rdPtr_q + AW'(1) : rdPtr_q;
    memCount_d = memCount_q;
    case ({doWrite, doFetch})
      2'b10:   memCount_d = memCount_q + FW'(1);
      2'b01:   memCount_d = memCount_q - FW'(1);
      default: memCount_d = memCount_q;
    endcase
    overflow_d = overflow_q | (sample_valid_i & ~doWrite);
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q    <= StIdle;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      memCount_q <= '0;
      readData_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      memCount_q <= memCount_d;
      readData_q <= readData_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk_i) begin
    if (doWrite && !flush) begin
      mem[wrPtr_q] <= selSample;
    end
    if (doFetch) begin
      ramData_q <= mem[rdPtr_q];
    end
  end

  assign read_data_o    = readData_q;
  assign read_valid_o   = (state_q == StValid);
  assign overflow_o     = overflow_q;
  assign fill_level_o   = memCount_q + FW'(read_valid_o);
  assign buffer_ready_o = (fill_level_o >= FW'(READY_LEVEL));

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Self-checking bench for pcm_sample_buffer: constant vector table, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_pcm_sample_buffer;

  localparam int DEPTH = 8;
  localparam int RL    = 4;
  localparam int FW    = $clog2(DEPTH+2);

  logic          clk = 1'b0;
  logic          rst;
  logic          sampleValid;
  logic [23:0]   leftSample;
  logic [23:0]   rightSample;
  logic          clear;
  logic [23:0]   readData;
  logic          readValid;
  logic          readReady;
  logic          bufferReady;
  logic [FW-1:0] fillLevel;
  logic          overflow;

  always #5 clk = ~clk;

  pcm_sample_buffer #(
    .SELECT_LEFT(1'b1),
    .DEPTH(DEPTH),
    .READY_LEVEL(RL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sample_valid_i(sampleValid),
    .left_sample_i(leftSample),
    .right_sample_i(rightSample),
    .clear_i(clear),
    .read_data_o(readData),
    .read_valid_o(readValid),
    .read_ready_i(readReady),
    .buffer_ready_o(bufferReady),
    .fill_level_o(fillLevel),
    .overflow_o(overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: RAM contents as a FIFO queue, one in-flight fetch slot, one output slot.
  logic [23:0] mQ[$];
  bit          mOutValid;
  logic [23:0] mOutData;
  bit          mInFlight;
  logic [23:0] mFlightData;
  bit          mOvf;

  logic [23:0] got[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    bit accept, fetch, wr;
    if (rst || clear) begin
      mQ.delete();
      mOutValid = 0;
      mOutData  = '0;
      mInFlight = 0;
      mOvf      = 0;
      return;
    end
    accept = mOutValid && readReady;
    fetch  = (mQ.size() > 0) && ((!mOutValid && !mInFlight) || accept);
    wr     = sampleValid && (mQ.size() < DEPTH);
    if (sampleValid && !wr) mOvf = 1;
    if (mInFlight) begin
      mOutValid = 1;
      mOutData  = mFlightData;
      mInFlight = 0;
    end else if (accept) begin
      mOutValid = 0;
    end
    if (fetch) begin
      mInFlight   = 1;
      mFlightData = mQ.pop_front();
    end
    if (wr) mQ.push_back(leftSample);
  endtask

  task automatic checkModel();
    int fill;
    fill = mQ.size() + (mOutValid ? 1 : 0);
    checkOutput("valid", readValid, mOutValid);
    if (mOutValid) checkOutput("data", readData, mOutData);
    checkOutput("fill", fillLevel, fill);
    checkOutput("bufready", bufferReady, fill >= RL);
    checkOutput("overflow", overflow, mOvf);
  endtask

  task automatic tick();
    if (readValid && readReady && !rst && !clear) got.push_back(readData);
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input logic sv, input logic [23:0] l, input logic [23:0] r,
                               input logic rdy, input logic clr);
    sampleValid = sv;
    leftSample  = l;
    rightSample = r;
    readReady   = rdy;
    clear       = clr;
    tick();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 24'h0, 24'h0, rdy, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
    rst = 1'b0;
    got.delete();
  endtask

  typedef struct {
    logic        sv;
    logic        rdy;
    logic [23:0] l;
    logic [23:0] r;
    logic        expValid;
    logic [23:0] expData;
    logic [3:0]  expFill;
    logic        expRdy;
    logic        expOvf;
  } vec_t;

  vec_t vecs[5];

  initial begin
    rst = 1'b1; sampleValid = 1'b0; leftSample = '0; rightSample = '0;
    clear = 1'b0; readReady = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 24'h7FFFFF, 24'h000001, 1'b0, 24'h0,      4'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 24'h0,      24'h0,      1'b0, 24'h0,      4'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 24'h0,      24'h0,      1'b1, 24'h7FFFFF, 4'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 24'h0,      24'h0,      1'b0, 24'h0,      4'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 24'h0,      24'h0,      1'b0, 24'h0,      4'd0, 1'b0, 1'b0};

    doReset();
    checkOutput("rst_valid", readValid, 1'b0);
    checkOutput("rst_data", readData, 24'h0);
    checkOutput("rst_fill", fillLevel, 0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_bufready", bufferReady, 1'b0);

    $display("[TB] single sample table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].l, vecs[i].r, vecs[i].rdy, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), readValid, vecs[i].expValid);
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d_data", i), readData, vecs[i].expData);
      checkOutput($sformatf("vec%0d_fill", i), fillLevel, vecs[i].expFill);
      checkOutput($sformatf("vec%0d_bufready", i), bufferReady, vecs[i].expRdy);
      checkOutput($sformatf("vec%0d_ovf", i), overflow, vecs[i].expOvf);
    end

    $display("[TB] ordering and wrap");
    doReset();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 24'(i), 24'hABC000 + 24'(i), 1'b1, 1'b0);
      idle(3, 1'b1);
    end
    idle(8, 1'b1);
    checkOutput("wrap_count", got.size(), 20);
    for (int i = 0; i < got.size() && i < 20; i++)
      checkOutput($sformatf("wrap_item%0d", i), got[i], 24'(i + 1));
    checkOutput("wrap_ovf", overflow, 1'b0);

    $display("[TB] back-pressure and full");
    doReset();
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 24'(i), 24'hFFF000, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("full_fill", fillLevel, 9);
    checkOutput("full_ovf", overflow, 1'b1);
    checkOutput("full_valid", readValid, 1'b1);
    checkOutput("full_data", readData, 24'd1);
    idle(4, 1'b0);
    checkOutput("full_data_held", readData, 24'd1);
    idle(40, 1'b1);
    checkOutput("full_drain_count", got.size(), 9);
    for (int i = 0; i < got.size() && i < 9; i++)
      checkOutput($sformatf("full_item%0d", i), got[i], 24'(i + 1));
    checkOutput("full_ovf_sticky", overflow, 1'b1);

    $display("[TB] threshold");
    doReset();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 24'h800000 + 24'(k), 24'h0, 1'b0, 1'b0);
      idle(3, 1'b0);
      checkOutput($sformatf("thr_after%0d", k), bufferReady, k >= RL);
    end
    applyStimulus(1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
    idle(2, 1'b0);
    checkOutput("thr_drain_fill", fillLevel, 3);
    checkOutput("thr_drain_bufready", bufferReady, 1'b0);

    $display("[TB] simultaneous write and accept");
    doReset();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 24'h100 + 24'(i), 24'h0, 1'b1, 1'b0);
      checkOutput("simul_bound_a", fillLevel <= 2, 1'b1);
      applyStimulus(1'b0, 24'h0, 24'h0, 1'b1, 1'b0);
      checkOutput("simul_bound_b", fillLevel <= 2, 1'b1);
    end
    idle(6, 1'b1);
    checkOutput("simul_count", got.size(), 30);

    $display("[TB] clear mid-operation");
    doReset();
    for (int i = 1; i <= 10; i++) applyStimulus(1'b1, 24'(i), 24'h0, 1'b0, 1'b0);
    idle(3, 1'b0);
    checkOutput("clr_pre_valid", readValid, 1'b1);
    applyStimulus(1'b1, 24'h55AA55, 24'h0, 1'b0, 1'b1);
    checkOutput("clr_valid", readValid, 1'b0);
    checkOutput("clr_fill", fillLevel, 0);
    checkOutput("clr_ovf", overflow, 1'b0);
    idle(4, 1'b1);
    checkOutput("clr_nostore_valid", readValid, 1'b0);
    checkOutput("clr_nostore_fill", fillLevel, 0);

    $display("[TB] randomized traffic");
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic sv, rdy, clr;
      sv  = ($urandom_range(0, 2) != 0);
      rdy = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 349) == 0);
      applyStimulus(sv, 24'($urandom), 24'($urandom), rdy, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
